// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM state encoding,
// RISC-V load/store funct3 codes, default data-memory address width, and
// small request-decode helpers used by the top-level FSM.
package lsu_pkg;

    localparam int MEM_ADDR_W_DEFAULT = 5;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPT,
        S_MERGE,
        S_WRITE,
        S_RESP
    } state_t;

    // Loads accept B/H/W/BU/HU; stores accept only B/H/W.
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !is_store;
            default:          return 1'b0;
        endcase
    endfunction

    // Halfword needs addr[0]=0, word needs addr[1:0]=0.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] offset);
        case (f3)
            F3_H, F3_HU: return offset[0];
            F3_W:        return offset != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Purely combinational lane logic for the load/store unit:
//   - load extract: pick byte/halfword/word from a memory word, sign- or
//     zero-extend according to funct3 (little-endian lanes).
//   - store merge: overlay the right-aligned store data onto the old word at
//     the addressed byte/halfword lane.
// Low address bits that are irrelevant for the access size are ignored, so a
// misaligned access is implicitly aligned down.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed lanes and build both the load result and the merged store word.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        load_data  = old_word;
        merge_data = old_word;
        byte_sel   = old_word[{offset, 3'b000} +: 8];
        half_sel   = old_word[{offset[1], 4'b0000} +: 16];

        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'h000000, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'h0000, half_sel};
            default: load_data = old_word;
        endcase

        case (funct3[1:0])
            2'b00:   merge_data[{offset, 3'b000} +: 8]     = wdata[7:0];
            2'b01:   merge_data[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            default: merge_data = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the data-memory port. Accepts one
// request at a time, performs B/H/W loads with extension and sub-word stores
// as read-modify-write against a 1-cycle registered-read block RAM, and
// returns a single-cycle response pulse.
// Optional feature macro: LSU_MISALIGN_TRAP_EN -- when defined, misaligned
// H/HU/W accesses respond with an error and never touch memory; otherwise
// the address is aligned down silently.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_ADDR_W = MEM_ADDR_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_store,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_error,
    output logic                  mem_en,
    output logic                  mem_read_en,
    output logic                  mem_write_en,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [31:0]           mem_write_data,
    input  logic [31:0]           mem_read_data
);

    state_t                state;
    logic [MEM_ADDR_W+1:0] addr_q;
    logic [2:0]            funct3_q;
    logic                  is_store_q;
    logic                  error_q;
    // Holds store data on accept, then the extracted load or merged store word.
    logic [31:0]           data_q;

    logic [31:0]           load_data;
    logic [31:0]           merge_data;
    logic                  req_misaligned;

    // Byte address bits above the memory window wrap away.
    logic                  unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:MEM_ADDR_W+2];

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_misaligned = f3_misaligned(req_funct3, req_addr[1:0]);
`else
    assign req_misaligned = 1'b0;
`endif

    lsu_align u_align (
        .funct3     (funct3_q),
        .offset     (addr_q[1:0]),
        .old_word   (mem_read_data),
        .wdata      (data_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    // Request FSM: capture on accept, sequence memory access, pulse response.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state      <= S_IDLE;
            addr_q     <= '0;
            funct3_q   <= '0;
            is_store_q <= 1'b0;
            error_q    <= 1'b0;
            data_q     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q     <= req_addr[MEM_ADDR_W+1:0];
                        funct3_q   <= req_funct3;
                        is_store_q <= req_is_store;
                        data_q     <= req_wdata;
                        if (!f3_legal(req_is_store, req_funct3) || req_misaligned) begin
                            error_q <= 1'b1;
                            state   <= S_RESP;
                        end else begin
                            error_q <= 1'b0;
                            state   <= (req_is_store && req_funct3 == F3_W) ? S_WRITE : S_READ;
                        end
                    end
                end
                S_READ:  state <= is_store_q ? S_MERGE : S_CAPT;
                S_CAPT: begin
                    data_q <= load_data;
                    state  <= S_RESP;
                end
                S_MERGE: begin
                    data_q <= merge_data;
                    state  <= S_WRITE;
                end
                S_WRITE: state <= S_RESP;
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode from the state register and captured registers only.
    assign req_ready      = (state == S_IDLE);
    assign resp_valid     = (state == S_RESP);
    assign resp_error     = resp_valid & error_q;
    assign resp_rdata     = (resp_valid && !is_store_q && !error_q) ? data_q : 32'h0;
    assign mem_read_en    = (state == S_READ);
    assign mem_write_en   = (state == S_WRITE);
    assign mem_en         = mem_read_en | mem_write_en;
    assign mem_addr       = addr_q[MEM_ADDR_W+1:2];
    assign mem_write_data = data_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the data-memory port: accepts one load/store request at a time from the core's memory stage and drives the word-wide, single-write-enable block-RAM data memory (5-bit word address, 32-bit data, 1-cycle registered read). Performs RISC-V byte/halfword/word load extraction with sign/zero extension. Implements sub-word stores as read-modify-write. Returns a single-cycle response pulse to the core.

## Interface
- MEM_ADDR_W, 5, word-address width of the data memory; request address bits [MEM_ADDR_W+1:2] select the word.
- Clock  in  1  rising-edge clock, shared with data memory
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; handshake = req_valid & req_ready
- req_is_store  in  1  1 = store, 0 = load
- req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 only (stores)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle response pulse; no backpressure
- resp_rdata  out  32  load result (0 for stores/errors)
- resp_error  out  1  qualified by resp_valid; illegal funct3 (or misaligned, see Configuration)
- mem_en  out  1  data-memory enable
- mem_read_en  out  1  read strobe
- mem_write_en  out  1  write strobe
- mem_addr  out  MEM_ADDR_W  word address
- mem_write_data  out  32  full word to write
- mem_read_data  in  32  valid one cycle after the read-strobe cycle

## Operation
- States: IDLE, READ, CAPT, MERGE, WRITE, RESP.
- IDLE: on handshake, register addr/funct3/wdata/is_store, then:
  - illegal funct3 -> RESP with error
  - load or sub-word store -> READ
  - word store -> WRITE
- READ: mem_en=mem_read_en=1, mem_addr = captured word index. Next state: CAPT (load) or MERGE (store).
- CAPT: register extracted load data from mem_read_data. Byte lane = addr[1:0], halfword lane = addr[1]. Little-endian. Sign-extend B/H, zero-extend BU/HU. Next state: RESP.
- MERGE: replace the addressed byte/halfword of mem_read_data with req_wdata[7:0]/[15:0]. Register the result. Next state: WRITE.
- WRITE: mem_en=mem_write_en=1, mem_write_data = full word or merged word. Next state: RESP.
- RESP: resp_valid=1 for exactly one cycle. Next state: IDLE.
- Memory-side outputs are decoded from the state register and captured registers only; there is no combinational path from req_* to mem_*.
- Address bits above MEM_ADDR_W+1 are ignored; addresses wrap modulo 2^(MEM_ADDR_W+2) bytes.
- req_* are ignored outside IDLE.

## Timing
- Handshake in cycle N. Then:
  - error: resp_valid at N+1
  - word store: write strobe at N+1, resp_valid at N+2
  - load: read strobe at N+1, resp_valid at N+3
  - sub-word store: read strobe N+1, merge N+2, write strobe N+3, resp_valid N+4
- Next request is accepted at the cycle after RESP, at the earliest.
- Reset values: all outputs 0, except req_ready=1 (state IDLE).
- Reset asserted mid-operation:
  - return to IDLE immediately (asynchronously); mem_write_en drops at once
  - a pending read-modify-write is abandoned without writing
  - no response is issued for the aborted request

## Configuration
- LSU_MISALIGN_TRAP_EN defined: H/HU with addr[0]=1, or W with addr[1:0]!=0, goes IDLE -> RESP with resp_error=1 and no memory access.
- LSU_MISALIGN_TRAP_EN undefined: the address is silently aligned down (H: addr[0] ignored; W: addr[1:0] ignored) and the access proceeds normally. resp_error is then only raised for illegal funct3.

## Structure
- Package lsu_pkg holds:
  - state enum
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - MEM_ADDR_W default
- Sub-module lsu_align, purely combinational:
  - load extract/extend: funct3, addr[1:0], word -> result
  - store merge: funct3, addr[1:0], old word, wdata -> new word
- The top level holds the FSM and registers.

## Test plan
- Memory word 3 = 0x11223344:
  - LB 0x0D -> 0x00000033
  - LB 0x0F -> 0x00000011
  - LH 0x0E -> 0x00001122
  - resp_valid at N+3 each time
- Word 5 = 0x80F000FF:
  - LB 0x14 -> 0xFFFFFFFF
  - LBU 0x14 -> 0x000000FF
  - LH 0x16 -> 0xFFFF80F0
- SB wdata 0x000000AB to 0x0D:
  - one read strobe at N+1, one write strobe at N+3, word 3 = 0x1122AB44, resp_valid N+4
- SW 0xDEADBEEF to 0x80:
  - mem_addr=0 (wrap), write strobe N+1, resp_valid N+2, no read strobe
- LW 0x0E:
  - with LSU_MISALIGN_TRAP_EN: resp_error=1 at N+1, mem_en never asserted
  - without: reads word 3 -> 0x11223344
- SH to 0x0C:
  - reset asserted during MERGE: mem_write_en never high, word 3 unchanged, outputs 0, req_ready=1
  - funct3=011 load: resp_error=1 at N+1
